// File: rtl/imem_fetch_unit_if.sv
`timescale 1ns/1ps
// Fetch request/response handshake plus the byte-wide program-load port.
interface imem_fetch_unit_if #(
   parameter int unsigned ADDR_WIDTH = 64
);
   // program-load port
   logic                  ld_en;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [7:0]            ld_data;

   // fetch request
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;

   // fetch response
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_inst;
   logic [1:0]            resp_fault;

   // PC/fetch stage and loader side
   modport master (
      output ld_en, ld_addr, ld_data,
      output req_valid, req_addr,
      input  req_ready,
      input  resp_valid, resp_inst, resp_fault,
      output resp_ready
   );

   // instruction memory side
   modport slave (
      input  ld_en, ld_addr, ld_data,
      input  req_valid, req_addr,
      output req_ready,
      output resp_valid, resp_inst, resp_fault,
      input  resp_ready
   );
endinterface

// File: rtl/imem_fetch_unit.sv
`timescale 1ns/1ps
// Clocked, byte-addressed little-endian instruction store with a byte load
// port and a single-outstanding valid/ready fetch path of fixed latency.
module imem_fetch_unit #(
   parameter int unsigned ADDR_WIDTH   = 64,
   parameter int unsigned DEPTH_BYTES  = 64,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] NOP_WORD     = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             reset_n,
   imem_fetch_unit_if.slave bus
);

   localparam int unsigned IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH_BYTES);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);
   localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0]      IDX_TWO   = IDX_W'(2);
   localparam logic [IDX_W-1:0]      IDX_THREE = IDX_W'(3);

   // Reject parameter sets the datapath cannot honour.
   if ((DEPTH_BYTES < 4) || ((DEPTH_BYTES % 4) != 0)) begin : g_bad_depth
      $error("imem_fetch_unit: DEPTH_BYTES must be a multiple of 4 and at least 4");
   end
   if (READ_LATENCY < 1) begin : g_bad_latency
      $error("imem_fetch_unit: READ_LATENCY must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_inst;
   logic [1:0]       r_fault;

   logic [7:0]       r_mem [DEPTH_BYTES];

   logic             w_req_ready;
   logic             w_resp_valid;
   logic             w_accept;
   logic             w_ld_in_range;
   logic             w_misaligned;
   logic             w_out_of_range;
   logic [1:0]       w_fault;
   logic [IDX_W-1:0] w_rd_base;
   logic [31:0]      w_rd_word;

   // Load writes land only inside the array; anything at or past DEPTH_BYTES is dropped.
   assign w_ld_in_range = (bus.ld_addr < DEPTH_A);

   // Fault decode: both checks are independent and may be set together.
   assign w_misaligned   = (bus.req_addr[1:0] != 2'b00);
   assign w_out_of_range = (bus.req_addr > LAST_WORD);
   assign w_fault        = {w_out_of_range, w_misaligned};

   // An out-of-range address never indexes the array, so no wrap-around read can occur.
   assign w_rd_base = w_out_of_range ? '0 : bus.req_addr[IDX_W-1:0];
   assign w_rd_word = {r_mem[w_rd_base + IDX_THREE],
                       r_mem[w_rd_base + IDX_TWO],
                       r_mem[w_rd_base + IDX_ONE],
                       r_mem[w_rd_base]};

   assign w_accept = bus.req_valid && w_req_ready;

   // Program-load write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (bus.ld_en && w_ld_in_range) begin
         r_mem[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE, one fetch in flight.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (READ_LATENCY > 1) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (r_cnt == CNT_ONE) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state; a load in IDLE blocks acceptance.
   always_comb begin
      w_req_ready  = 1'b0;
      w_resp_valid = 1'b0;
      case (r_state)
         S_IDLE:  w_req_ready  = !bus.ld_en;
         S_RESP:  w_resp_valid = 1'b1;
         default: ;
      endcase
   end

   // Holding register and latency counter; the word is frozen at accept time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_inst  <= NOP_WORD;
         r_fault <= 2'b00;
      end else if (w_accept) begin
         r_inst  <= (w_fault != 2'b00) ? NOP_WORD : w_rd_word;
         r_fault <= w_fault;
         r_cnt   <= CNT_LOAD;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt - CNT_ONE;
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = w_resp_valid;
   assign bus.resp_inst  = r_inst;
   assign bus.resp_fault = r_fault;

endmodule

// File: tb/tb_imem_fetch_unit.sv
`timescale 1ns/1ps
// Two instances (latency 1 and 3) share the load port; each has its own fetch
// handshake and its own expected-response queue checked by a monitor.
module tb_imem_fetch_unit;

   localparam int unsigned AW  = 64;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] inst;
      logic [1:0]  fault;
   } exp_t;

   logic            clk;
   logic            reset_n;
   logic            ld_en;
   logic [AW-1:0]   ld_addr;
   logic [7:0]      ld_data;
   logic [1:0]      req_valid_v;
   logic [1:0]      resp_ready_v;
   logic [AW-1:0]   req_addr_v [2];
   logic [1:0]      req_ready_v;
   logic [1:0]      resp_valid_v;
   logic [31:0]     resp_inst_v [2];
   logic [1:0]      resp_fault_v [2];

   exp_t q0[$];
   exp_t q1[$];

   int n_checks = 0;
   int n_fail   = 0;

   imem_fetch_unit_if #(.ADDR_WIDTH(AW)) if0 ();
   imem_fetch_unit_if #(.ADDR_WIDTH(AW)) if1 ();

   assign if0.ld_en      = ld_en;
   assign if0.ld_addr    = ld_addr;
   assign if0.ld_data    = ld_data;
   assign if0.req_valid  = req_valid_v[0];
   assign if0.req_addr   = req_addr_v[0];
   assign if0.resp_ready = resp_ready_v[0];
   assign if1.ld_en      = ld_en;
   assign if1.ld_addr    = ld_addr;
   assign if1.ld_data    = ld_data;
   assign if1.req_valid  = req_valid_v[1];
   assign if1.req_addr   = req_addr_v[1];
   assign if1.resp_ready = resp_ready_v[1];

   assign req_ready_v[0]  = if0.req_ready;
   assign resp_valid_v[0] = if0.resp_valid;
   assign resp_inst_v[0]  = if0.resp_inst;
   assign resp_fault_v[0] = if0.resp_fault;
   assign req_ready_v[1]  = if1.req_ready;
   assign resp_valid_v[1] = if1.resp_valid;
   assign resp_inst_v[1]  = if1.resp_inst;
   assign resp_fault_v[1] = if1.resp_fault;

   imem_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH_BYTES(64), .READ_LATENCY(1), .NOP_WORD(NOP))
      u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
   imem_fetch_unit #(.ADDR_WIDTH(AW), .DEPTH_BYTES(64), .READ_LATENCY(3), .NOP_WORD(NOP))
      u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: compare whenever a response is handed over.
   always @(negedge clk) begin
      if (reset_n && resp_valid_v[0] && resp_ready_v[0]) begin
         if (q0.size() == 0) begin
            chk("sb0_unexpected_resp", 64'(resp_inst_v[0]), 64'(NOP) + 64'h1_0000_0000);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("sb0_inst", 64'(resp_inst_v[0]), 64'(e.inst));
            chk("sb0_fault", 64'(resp_fault_v[0]), 64'(e.fault));
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n && resp_valid_v[1] && resp_ready_v[1]) begin
         if (q1.size() == 0) begin
            chk("sb1_unexpected_resp", 64'(resp_inst_v[1]), 64'(NOP) + 64'h1_0000_0000);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("sb1_inst", 64'(resp_inst_v[1]), 64'(e.inst));
            chk("sb1_fault", 64'(resp_fault_v[1]), 64'(e.fault));
         end
      end
   end

   // All stimulus tasks start and end one time unit after a rising edge.
   task automatic load_byte(input logic [AW-1:0] a, input logic [7:0] d);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(posedge clk); #1;
      ld_en   = 1'b0;
   endtask

   task automatic load_word(input logic [AW-1:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) load_byte(a + AW'(i), w[8*i +: 8]);
   endtask

   // Raise a request and wait (bounded) until it is accepted.
   task automatic issue(input int s, input logic [AW-1:0] a, output bit ok);
      ok            = 1'b0;
      req_addr_v[s] = a;
      req_valid_v[s] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready_v[s]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
      end
      if (ok) @(posedge clk);
      #1;
      req_valid_v[s] = 1'b0;
      chk("req_accepted", 64'(ok), 64'd1);
   endtask

   // Full fetch: queue expectation, issue, check latency, optional hold, release.
   task automatic fetch(input int s, input logic [AW-1:0] a, input logic [31:0] e_inst,
                        input logic [1:0] e_fault, input int hold, input bit ld_wait);
      bit ok;
      bit seen;
      int lat;
      exp_t e;
      e.inst  = e_inst;
      e.fault = e_fault;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
      resp_ready_v[s] = (hold == 0);
      issue(s, a, ok);
      if (!ok) begin
         if (s == 0) void'(q0.pop_back()); else void'(q1.pop_back());
         resp_ready_v[s] = 1'b1;
         return;
      end
      if (ld_wait) begin
         ld_en   = 1'b1;
         ld_addr = a;
         ld_data = 8'hFF;
      end
      lat  = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         lat++;
         if (resp_valid_v[s]) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
         ld_en = 1'b0;
      end
      ld_en = 1'b0;
      chk("latency", seen ? 64'(lat) : 64'd0, (s == 0) ? 64'd1 : 64'd3);
      if (!seen) begin
         if (s == 0) void'(q0.pop_back()); else void'(q1.pop_back());
         resp_ready_v[s] = 1'b1;
         return;
      end
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 64'(resp_valid_v[s]), 64'd1);
         chk("hold_inst", 64'(resp_inst_v[s]), 64'(e_inst));
         chk("hold_fault", 64'(resp_fault_v[s]), 64'(e_fault));
         chk("hold_req_ready", 64'(req_ready_v[s]), 64'd0);
         @(posedge clk); #1;
         if (i == hold - 1) resp_ready_v[s] = 1'b1;
         else @(negedge clk);
      end
      @(posedge clk); #1;
      chk("resp_valid_drop", 64'(resp_valid_v[s]), 64'd0);
   endtask

   initial begin
      bit ok;
      int cnt;
      reset_n        = 1'b0;
      ld_en          = 1'b0;
      ld_addr        = '0;
      ld_data        = '0;
      req_valid_v    = 2'b00;
      resp_ready_v   = 2'b11;
      req_addr_v[0]  = '0;
      req_addr_v[1]  = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_req_ready", 64'(req_ready_v[s]), 64'd1);
         chk("rst_resp_valid", 64'(resp_valid_v[s]), 64'd0);
         chk("rst_resp_inst", 64'(resp_inst_v[s]), 64'(NOP));
         chk("rst_resp_fault", 64'(resp_fault_v[s]), 64'd0);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;

      // basic fetch, latency 1
      load_byte(64'd0, 8'h83);
      load_byte(64'd1, 8'h34);
      load_byte(64'd2, 8'h85);
      load_byte(64'd3, 8'h02);
      fetch(0, 64'd0, 32'h0285_3483, 2'b00, 0, 1'b0);

      load_word(64'd4,  32'h009A_84B3);
      load_word(64'd8,  32'h00B5_0533);
      load_word(64'd12, 32'h0295_3423);
      load_word(64'd60, 32'h1234_5678);

      // load past the end is dropped rather than aliased onto byte 0
      load_byte(64'd64, 8'h55);
      fetch(0, 64'd0, 32'h0285_3483, 2'b00, 0, 1'b0);

      // latency 3 with a stalled consumer
      fetch(1, 64'd12, 32'h0295_3423, 2'b00, 4, 1'b0);
      fetch(0, 64'd8,  32'h00B5_0533, 2'b00, 0, 1'b0);
      fetch(0, 64'd60, 32'h1234_5678, 2'b00, 0, 1'b0);

      // faults
      fetch(0, 64'd2,  NOP, 2'b01, 0, 1'b0);
      fetch(0, 64'd64, NOP, 2'b10, 0, 1'b0);
      fetch(0, 64'd66, NOP, 2'b11, 0, 1'b0);
      fetch(0, 64'd58, NOP, 2'b01, 0, 1'b0);
      fetch(0, 64'd61, NOP, 2'b11, 0, 1'b0);
      fetch(0, 64'h0000_0100_0000_0000, NOP, 2'b10, 0, 1'b0);
      fetch(1, 64'd6,  NOP, 2'b01, 2, 1'b0);

      // load and request together: load wins, fetch follows with the new byte
      resp_ready_v[1] = 1'b1;
      ld_en           = 1'b1;
      ld_addr         = 64'd8;
      ld_data         = 8'hAA;
      req_addr_v[1]   = 64'd8;
      req_valid_v[1]  = 1'b1;
      @(negedge clk);
      chk("ld_blocks_req", 64'(req_ready_v[1]), 64'd0);
      @(posedge clk); #1;
      ld_en = 1'b0;
      fetch(1, 64'd8, 32'h00B5_05AA, 2'b00, 0, 1'b0);

      // a load during WAIT does not disturb the captured word, but does take effect
      fetch(1, 64'd4, 32'h009A_84B3, 2'b00, 0, 1'b1);
      fetch(0, 64'd4, 32'h009A_84FF, 2'b00, 0, 1'b0);

      // reset during WAIT drops the request
      resp_ready_v[1] = 1'b1;
      issue(1, 64'd0, ok);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_resp_valid", 64'(resp_valid_v[1]), 64'd0);
      chk("rst_mid_req_ready", 64'(req_ready_v[1]), 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid_v[1]) cnt++;
      end
      chk("no_resp_after_reset", 64'(cnt), 64'd0);
      @(posedge clk); #1;
      chk("post_rst_req_ready", 64'(req_ready_v[1]), 64'd1);
      fetch(1, 64'd0, 32'h0285_3483, 2'b00, 0, 1'b0);

      repeat (2) @(posedge clk);
      chk("sb0_drained", 64'(q0.size()), 64'd0);
      chk("sb1_drained", 64'(q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time bound so a stuck handshake cannot hang the run.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised, clocked successor to the single-cycle combinational instruction memory.
- Byte-addressed, little-endian instruction store with a byte-wide program-load port and a valid/ready fetch request/response interface.
- Read latency is configurable. Misaligned and out-of-range fetches are flagged.
- Sits between the PC/fetch stage and the decode stage of the RISC-V core.

Parameters:
- ADDR_WIDTH, 64: width of fetch and load addresses.
- DEPTH_BYTES, 64: memory size in bytes; must be a multiple of 4, at least 4.
- READ_LATENCY, 1: cycles from request accept to resp_valid; must be at least 1.
- NOP_WORD, 32'h00000013: instruction returned on a faulting fetch (addi x0,x0,0).

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous, active-low reset.
- ld_en, input, 1: program-load byte write strobe.
- ld_addr, input, ADDR_WIDTH: byte address for the load write.
- ld_data, input, 8: byte to write.
- req_valid, input, 1: fetch request valid.
- req_ready, output, 1: unit can accept a fetch this cycle.
- req_addr, input, ADDR_WIDTH: fetch byte address (PC).
- resp_valid, output, 1: response valid.
- resp_ready, input, 1: consumer accepts the response.
- resp_inst, output, 32: fetched instruction, {mem[a+3],mem[a+2],mem[a+1],mem[a]}.
- resp_fault, output, 2: bit0 = misaligned (req_addr[1:0] != 0); bit1 = out of range (req_addr > DEPTH_BYTES-4).

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE; latency counter 0; req_ready=1; resp_valid=0; resp_inst=NOP_WORD; resp_fault=0.
  - Memory contents are NOT cleared; they retain the last loaded bytes.
- Load port:
  - ld_en=1 writes ld_data to mem[ld_addr] at the clock edge, in any state.
  - If ld_addr >= DEPTH_BYTES, the write is silently dropped.
- Load/fetch priority: in IDLE, when ld_en=1, req_ready=0 that cycle. Load has priority and no fetch is accepted in the same cycle as a load.
- States:
  - IDLE:
    - req_ready = !ld_en.
    - On req_valid && req_ready: the word at req_addr (or NOP_WORD if any fault bit is set) and the fault bits are captured into a holding register at that edge.
    - Later loads do not alter the captured word.
    - Next state is WAIT if READ_LATENCY > 1 (counter loaded with READ_LATENCY-1); otherwise RESP.
  - WAIT: req_ready=0; counter decrements each cycle; go to RESP when the counter reaches 1.
  - RESP:
    - resp_valid=1; resp_inst and resp_fault are driven from the holding register and held stable while resp_ready=0.
    - On resp_ready=1 go to IDLE; resp_valid is 0 the next cycle.
    - req_ready=0 in RESP. No back-to-back overlap: one outstanding fetch at a time.
- Latency: request accepted at edge N gives resp_valid=1 in the cycle after edge N+READ_LATENCY-1. With READ_LATENCY=1, resp_valid is high the cycle immediately after acceptance.
- Fault handling:
  - The misaligned and out-of-range checks are evaluated independently; both bits may be set.
  - A faulting fetch still completes the full handshake with NOP_WORD.
  - No memory bytes beyond DEPTH_BYTES-1 are ever read; no index wrap-around.
- Address width: only the low clog2(DEPTH_BYTES) bits index memory. Any higher set bit makes the fetch out of range.
- Reset mid-operation: an in-flight request is dropped with no response; the unit re-enters IDLE with req_ready=1 after reset_n rises.
- resp_inst and resp_fault hold their last value while resp_valid=0. They are don't-care to consumers.

Test Plan:
1. Load bytes 83,34,85,02 at 0..3; fetch addr 0 with READ_LATENCY=1 -> resp_valid the next cycle, resp_inst=32'h02853483, resp_fault=0.
2. Load 16 bytes (four instructions at 0,4,8,12); fetch addr 12 with READ_LATENCY=3 -> resp_valid exactly 3 cycles after accept, resp_inst=32'h02953423; hold resp_ready=0 for 4 cycles -> outputs stable, req_ready=0 throughout.
3. Fetch addr 2 -> resp_fault=2'b01, resp_inst=32'h00000013. Fetch addr 64 with DEPTH_BYTES=64 -> resp_fault=2'b10. Fetch addr 66 -> resp_fault=2'b11.
4. ld_en and req_valid both high in IDLE -> req_ready=0 and the byte is written. Next cycle with ld_en=0 the fetch is accepted and returns the newly written byte.
5. Fetch addr 4 is accepted, then ld_en rewrites byte 4 during WAIT -> response returns the old word 32'h009A84B3.
6. Pull reset_n low during WAIT -> resp_valid=0 immediately and no response follows. After reset, req_ready=1, and a refetch of addr 0 returns 32'h02853483 (memory retained).
